// File: rtl/sid_wp_if.sv
// Command handshake into the SID write player: 31-bit timed command words.
interface sid_wp_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [30:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/sid_write_player.sv
// Replays buffered, delay-timed SID register writes/reads onto the sid_top CPU port.
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued command
//   LOAD  | command popped into cmd_q, counter loaded
//   WAIT  | counting ce_1m ticks down to zero
//   ISSUE | bus strobes active for one clk
//   RD1   | read: sid_top settling, data captured at end
//   RD2   | read: rd_valid pulse
module sid_write_player #(
  parameter int DUAL    = 1,
  parameter int FIFO_AW = 4,
  localparam int N      = (DUAL != 0) ? 2 : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_1m,
  sid_wp_if.slave          cmd,
  input  logic             flush,
  input  logic             pause,
  output logic [N-1:0]     sid_cs,
  output logic             sid_we,
  output logic [4:0]       sid_addr,
  output logic [7:0]       sid_wdata,
  input  logic [7:0]       sid_rdata,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, ISSUE, RD1, RD2} state_t;

  state_t             state;
  logic [30:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [30:0]        cmd_q;
  logic [15:0]        cnt;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               chip_sel;
  logic [N-1:0]       cs_val;

  assign full          = (level == (FIFO_AW+1)'(DEPTH));
  assign empty         = (level == '0);
  assign cmd.cmd_ready = ~full;
  assign push          = cmd.cmd_valid & ~full & ~flush;
  // A finished write or read hands straight over to the next queued command.
  assign pop           = ~flush & ~empty &
                         ((state == IDLE) | ((state == ISSUE) & ~cmd_q[29]) | (state == RD2));
  assign chip_sel      = (DUAL != 0) ? cmd_q[30] : 1'b0;
  assign cs_val        = N'(1) << chip_sel;
  assign busy          = (level != '0) | (state != IDLE);
  assign fifo_level    = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd.cmd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cmd_q     <= '0;
      cnt       <= '0;
      sid_cs    <= '0;
      sid_we    <= 1'b0;
      sid_addr  <= '0;
      sid_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      sid_cs   <= '0;
      sid_we   <= 1'b0;
      rd_valid <= 1'b0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end

      if (pop) begin
        cmd_q <= mem[rd_ptr];
        cnt   <= mem[rd_ptr][15:0];
      end

      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:  if (pop) state <= LOAD;
          LOAD:  state <= WAIT;
          WAIT: begin
            if (ce_1m && !pause) begin
              if (cnt == '0) begin
                state     <= ISSUE;
                sid_cs    <= cs_val;
                sid_we    <= ~cmd_q[29];
                sid_addr  <= cmd_q[28:24];
                sid_wdata <= cmd_q[23:16];
              end else begin
                cnt <= cnt - 16'd1;
              end
            end
          end
          ISSUE: begin
            if (cmd_q[29]) state <= RD1;
            else           state <= pop ? LOAD : IDLE;
          end
          RD1: begin
            state    <= RD2;
            rd_data  <= sid_rdata;
            rd_valid <= 1'b1;
          end
          RD2:     state <= pop ? LOAD : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
